// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle FSM and the datapath/memory it sequences.
// Latency: none (wires only).
// Backpressure: mem_ready from memory stalls the FSM in its memory states.
interface multicycle_control_fsm_if #(
    parameter int COUNT_WIDTH = 32
);
    logic [6:0]             opcode;
    logic                   zero;
    logic                   mem_ready;

    logic                   pc_write;
    logic                   pc_source;
    logic                   ir_write;
    logic                   iord;
    logic                   mem_read;
    logic                   mem_write;
    logic                   reg_write;
    logic                   mem_to_reg;
    logic                   alu_src_a;
    logic [1:0]             alu_src_b;
    logic [1:0]             alu_op;
    logic                   illegal;
    logic [3:0]             state;
    logic [COUNT_WIDTH-1:0] retired;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_source, ir_write, iord, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal, state, retired
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_source, ir_write, iord, mem_read, mem_write,
               reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               illegal, state, retired
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle RV32I-subset datapath, plus a retired-instruction counter.
// Latency: LOAD 5, STORE 4, R/I-ALU 4, BRANCH 3 cycles with memory always ready.
// Backpressure: mem_ready low holds FETCH/MEMRD/MEMWR with request and address select stable.
module multicycle_control_fsm #(
    parameter int COUNT_WIDTH = 32
) (
    input logic                     clk,
    input logic                     rst,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADDR = 4'd2,
        S_MEMRD   = 4'd3,
        S_LOADWB  = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_ALUWB   = 4'd8,
        S_BRANCH  = 4'd9,
        S_ILLEGAL = 4'd10
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    // Per-state control word; fetch_wr and branch_wr mark the two enables
    // that must follow mem_ready / zero within the same cycle.
    typedef struct packed {
        logic       pc_source;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal;
        logic       fetch_wr;
        logic       branch_wr;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.mem_read  = 1'b1;
                c.alu_src_b = 2'b01;
                c.fetch_wr  = 1'b1;
            end
            S_DECODE: begin
                c.alu_src_b = 2'b10;
            end
            S_MEMADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                c.mem_read = 1'b1;
                c.iord     = 1'b1;
            end
            S_LOADWB: begin
                c.reg_write  = 1'b1;
                c.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                c.mem_write = 1'b1;
                c.iord      = 1'b1;
            end
            S_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b10;
            end
            S_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b10;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.reg_write = 1'b1;
            end
            S_BRANCH: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b01;
                c.pc_source = 1'b1;
                c.branch_wr = 1'b1;
            end
            S_ILLEGAL: begin
                c.illegal = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    state_t                 state_q;
    state_t                 state_nxt;
    ctrl_t                  ctrl_q;
    logic [COUNT_WIDTH-1:0] retired_q;
    logic                   retire;

    always_comb begin
        state_nxt = S_FETCH;
        case (state_q)
            S_FETCH:   state_nxt = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LOAD, OP_STORE: state_nxt = S_MEMADDR;
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_I:              state_nxt = S_EXEC_I;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    default:           state_nxt = S_ILLEGAL;
                endcase
            end
            S_MEMADDR: state_nxt = (bus.opcode == OP_STORE) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_nxt = bus.mem_ready ? S_LOADWB : S_MEMRD;
            S_LOADWB:  state_nxt = S_FETCH;
            S_MEMWR:   state_nxt = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC_R:  state_nxt = S_ALUWB;
            S_EXEC_I:  state_nxt = S_ALUWB;
            S_ALUWB:   state_nxt = S_FETCH;
            S_BRANCH:  state_nxt = S_FETCH;
            S_ILLEGAL: state_nxt = S_ILLEGAL;
            default:   state_nxt = S_FETCH;
        endcase
    end

    assign retire = (state_q == S_LOADWB) || (state_q == S_ALUWB) ||
                    (state_q == S_BRANCH) || ((state_q == S_MEMWR) && bus.mem_ready);

    // Control word is registered from the next state so it lines up with state_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            ctrl_q    <= decode_ctrl(S_FETCH);
            retired_q <= '0;
        end else begin
            state_q <= state_nxt;
            ctrl_q  <= decode_ctrl(state_nxt);
            if (retire) begin
                retired_q <= retired_q + COUNT_ONE;
            end
        end
    end

    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_source  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.iord       = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = 2'b00;
        bus.alu_op     = 2'b00;
        bus.illegal    = 1'b0;
        if (!rst) begin
            bus.pc_source  = ctrl_q.pc_source;
            bus.iord       = ctrl_q.iord;
            bus.mem_read   = ctrl_q.mem_read;
            bus.mem_write  = ctrl_q.mem_write;
            bus.reg_write  = ctrl_q.reg_write;
            bus.mem_to_reg = ctrl_q.mem_to_reg;
            bus.alu_src_a  = ctrl_q.alu_src_a;
            bus.alu_src_b  = ctrl_q.alu_src_b;
            bus.alu_op     = ctrl_q.alu_op;
            bus.illegal    = ctrl_q.illegal;
            bus.ir_write   = ctrl_q.fetch_wr & bus.mem_ready;
            bus.pc_write   = (ctrl_q.fetch_wr & bus.mem_ready) | (ctrl_q.branch_wr & bus.zero);
        end
    end

    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle RV32I-subset datapath; sequences the shared ALU, instruction/data memory, IR, PC and register file.
- Drives ALUOp into the ALU control decoder using the existing encoding: 00 = add, 01 = subtract, 10 = decode from funct.
- Also counts retired instructions for debug and CPI measurement.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- Opcode  input  7  IR[6:0]; valid from DECODE onward.
- Zero  input  1  ALU zero flag.
- MemReady  input  1  memory completes the current access this cycle.
- PCWrite  output  1  PC load enable.
- PCSource  output  1  0 = ALU result, 1 = ALUOut register.
- IRWrite  output  1  IR load enable.
- IorD  output  1  memory address source: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- RegWrite  output  1  register file write enable.
- MemToReg  output  1  write-back source: 0 = ALUOut, 1 = MDR.
- ALUSrcA  output  1  0 = PC, 1 = rs1.
- ALUSrcB  output  2  00 = rs2, 01 = constant 4, 10 = immediate.
- ALUOp  output  2  to the ALU control decoder.
- Illegal  output  1  high while halted on an unsupported opcode.
- State  output  4  current state encoding (debug).
- Retired  output  COUNT_WIDTH  retired-instruction count.

Behaviour:
- State register:
  - Async Reset: State = FETCH (0), Retired = 0.
  - While Reset = 1, PCWrite, IRWrite, MemRead, MemWrite, RegWrite are forced to 0 and all other outputs are 0.
- Outputs are combinational from State, Zero and MemReady. Any output not listed for a state is 0.
- Opcodes: R 0110011, I-ALU 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011.
- States (encoding: outputs -> next state):
  - FETCH (0): MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 0; IRWrite = PCWrite = MemReady. Stay while MemReady = 0; when MemReady = 1 go to DECODE.
  - DECODE (1): ALUSrcA = 0, ALUSrcB = 10, ALUOp = 00 (branch target into ALUOut). Next: LOAD/STORE -> MEMADDR, R -> EXEC_R, I-ALU -> EXEC_I, BRANCH -> BRANCH, any other -> ILLEGAL.
  - MEMADDR (2): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. LOAD -> MEMRD, STORE -> MEMWR.
  - MEMRD (3): MemRead = 1, IorD = 1. Wait for MemReady, then go to LOADWB.
  - LOADWB (4): RegWrite = 1, MemToReg = 1 -> FETCH.
  - MEMWR (5): MemWrite = 1, IorD = 1. Wait for MemReady, then go to FETCH.
  - EXEC_R (6): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10 -> ALUWB.
  - EXEC_I (7): ALUSrcA = 1, ALUSrcB = 10, ALUOp = 10 -> ALUWB.
  - ALUWB (8): RegWrite = 1, MemToReg = 0 -> FETCH.
  - BRANCH (9): ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCSource = 1, PCWrite = Zero -> FETCH.
  - ILLEGAL (10): Illegal = 1, all write enables 0. Sticky; only Reset exits.
  - Encodings 11-15 are unreachable; if entered, go to FETCH on the next clock.
- Latency in cycles, with MemReady always 1:
  - LOAD: 5.
  - STORE: 4.
  - R / I-ALU: 4.
  - BRANCH: 3.
  - Each cycle of MemReady = 0 adds one wait cycle in FETCH, MEMRD or MEMWR.
- Memory handshake:
  - MemRead/MemWrite and the address select stay stable for the whole wait.
  - A MemReady pulse in a non-memory state is ignored.
- Retired counter:
  - Increments by 1 on the clock edge that leaves LOADWB, MEMWR (with MemReady), ALUWB or BRANCH.
  - Wraps from 2^COUNT_WIDTH-1 to 0.
  - Never increments in ILLEGAL.
- Reset mid-instruction (e.g. during MEMWR wait): State returns to FETCH immediately, no write completes, Retired clears.

Test Plan:
- Reset pulse mid-MEMRD wait -> State = 0, MemRead = 0 while Reset is high, Retired = 0; after release, FETCH with MemRead = 1, ALUSrcB = 01.
- R-type (Opcode 0110011), MemReady = 1 -> State sequence 0,1,6,8,0; ALUOp = 10 in state 6; RegWrite = 1 only in state 8; Retired = 1.
- LOAD with MemReady low 3 cycles in MEMRD -> sequence 0,1,2,3,3,3,3,4,0 (8 cycles); MemRead = 1 and IorD = 1 throughout state 3; MemToReg = 1 in state 4.
- BRANCH with Zero = 1, then a second BRANCH with Zero = 0 -> in state 9 ALUOp = 01 and PCSource = 1; PCWrite = 1 for the first and 0 for the second; Retired increments both times.
- Opcode 1111111 -> state 10; Illegal = 1 held for 20 cycles; no write enables; Retired unchanged; Reset recovers to FETCH.
- COUNT_WIDTH = 4, 17 R-type instructions -> Retired wraps and reads 1.
